// File: rtl/mydesign_seq_ctrl_if.sv
// Command, datapath-control and status bundle between the host
// and the mydesign sequencer.
interface mydesign_seq_ctrl_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic [1:0]       cmd_cin;
  logic             abort;
  logic             din1;
  logic             up1_dn0;
  logic             sel;
  logic             cin1;
  logic             cin2;
  logic             co1;
  logic             co2;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_cin,
    output abort, co1, co2,
    input  cmd_ready, din1, up1_dn0, sel,
    input  cin1, cin2, busy, done, aborted,
    input  carry_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_cin,
    input  abort, co1, co2,
    output cmd_ready, din1, up1_dn0, sel,
    output cin1, cin2, busy, done, aborted,
    output carry_cnt
  );
endinterface

// File: rtl/mydesign_seq_ctrl.sv
// Command sequencer for the mydesign datapath:
// IDLE -> RUN -> DRAIN -> DONE, with carry-out counting.
module mydesign_seq_ctrl #(
  parameter int LEN_W     = 4,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst,
  mydesign_seq_ctrl_if.slave bus
);
  localparam int CW = (LEN_W > 4) ? LEN_W : 4;
  localparam logic [CW-1:0] DRAIN_LAST =
    CW'(DRAIN_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_carry;
  logic             r_din1;
  logic             r_up;
  logic             r_sel;
  logic             r_cin1;
  logic             r_cin2;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             w_accept;
  logic             w_active;
  logic             w_co;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_co     = bus.co1 | bus.co2;
  assign w_last   = (r_cnt == '0);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid)
          w_nxt = (bus.cmd_len != '0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        if (bus.abort)
          w_nxt = S_DONE;
        else if (w_last)
          w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.abort || w_last)
          w_nxt = S_DONE;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_carry   <= '0;
      r_din1    <= 1'b0;
      r_up      <= 1'b1;
      r_sel     <= 1'b0;
      r_cin1    <= 1'b0;
      r_cin2    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_din1  <= (w_nxt == S_RUN);
      r_busy  <= (w_nxt != S_IDLE);
      r_done  <= (w_nxt == S_DONE);
      if (w_accept) begin
        r_up      <= ~bus.cmd_op[0];
        r_sel     <= bus.cmd_op[1];
        r_cin1    <= bus.cmd_cin[0];
        r_cin2    <= bus.cmd_cin[1];
        r_carry   <= '0;
        r_aborted <= 1'b0;
        r_cnt     <= (bus.cmd_len != '0) ?
                     CW'(bus.cmd_len) - CW'(1) :
                     DRAIN_LAST;
      end else if (w_active) begin
        if (w_co && (r_carry != '1))
          r_carry <= r_carry + CNT_W'(1);
        if (bus.abort)
          r_aborted <= 1'b1;
        // r_cnt is reused: run length first, then drain length
        if ((r_state == S_RUN) && w_last)
          r_cnt <= DRAIN_LAST;
        else
          r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE) && !rst;
  assign bus.din1      = r_din1;
  assign bus.up1_dn0   = r_up;
  assign bus.sel       = r_sel;
  assign bus.cin1      = r_cin1;
  assign bus.cin2      = r_cin2;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.aborted   = r_aborted;
  assign bus.carry_cnt = r_carry;
endmodule
